// File: rtl/fetch_thread_scheduler.sv
// Two-thread fetch scheduler: switch-on-event with a one-cycle SWITCH bubble.
// Define SCHED_QUANTUM_EN to add time-sliced round-robin (QUANTUM RUN cycles per slice).
module fetch_thread_scheduler #(
    parameter int QUANTUM = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_thread_en,
    input  logic       i_miss,
    input  logic [1:0] i_fill_done,
    input  logic       i_hc_stall,
    output logic       o_thread_id,
    output logic       o_switch,
    output logic       o_fetch_stall,
    output logic [1:0] o_blocked
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    if (QUANTUM < 2) begin : g_quantum_check
        $error("fetch_thread_scheduler: QUANTUM must be at least 2");
    end

    state_t     state, state_nxt;
    logic       thread_nxt;
    logic [1:0] blocked_nxt;
    logic [1:0] runnable;
    logic       cur, oth;
    logic       leave_run;
    logic       quantum_expired;

    assign cur      = o_thread_id;
    assign oth      = ~o_thread_id;
    // Registered blocked flags: a fill only makes its thread runnable one cycle later.
    assign runnable = i_thread_en & ~o_blocked;

    // A miss is honoured even under stall; an enable drop waits for the stall to clear.
    assign leave_run = i_miss | (~i_thread_en[cur] & ~i_hc_stall);

`ifdef SCHED_QUANTUM_EN
    localparam int CNT_W = $clog2(QUANTUM);

    logic [CNT_W-1:0] quantum_cnt, quantum_cnt_nxt;

    assign quantum_expired = (quantum_cnt == CNT_W'(QUANTUM - 1)) & ~i_hc_stall;

    // Counter only survives RUN->RUN; any state entry (or a slice renewal) clears it.
    always_comb begin
        quantum_cnt_nxt = '0;
        if (state == RUN && state_nxt == RUN) begin
            if (i_hc_stall)
                quantum_cnt_nxt = quantum_cnt;
            else if (!quantum_expired)
                quantum_cnt_nxt = quantum_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            quantum_cnt <= '0;
        else
            quantum_cnt <= quantum_cnt_nxt;
    end
`else
    assign quantum_expired = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        thread_nxt = o_thread_id;
        case (state)
            IDLE: begin
                if (runnable[oth]) begin
                    state_nxt  = SWITCH;
                    thread_nxt = oth;
                end else if (runnable[cur]) begin
                    state_nxt = RUN;
                end
            end
            SWITCH: state_nxt = RUN;
            RUN: begin
                if (leave_run) begin
                    if (runnable[oth]) begin
                        state_nxt  = SWITCH;
                        thread_nxt = oth;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (quantum_expired && runnable[oth]) begin
                    state_nxt  = SWITCH;
                    thread_nxt = oth;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Set on a RUN-state miss of the owning thread wins over a same-cycle fill.
    assign blocked_nxt = (o_blocked & ~i_fill_done)
                       | ({2{state == RUN && i_miss}} & (cur ? 2'b10 : 2'b01));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_thread_id <= 1'b0;
            o_blocked   <= 2'b00;
        end else begin
            state       <= state_nxt;
            o_thread_id <= thread_nxt;
            o_blocked   <= blocked_nxt;
        end
    end

    assign o_switch      = (state == SWITCH);
    assign o_fetch_stall = (state != RUN);

endmodule

// File: doc/fetch_thread_scheduler.md
# fetch_thread_scheduler

Two-thread fetch scheduler for the multithreaded MIPS core. Each cycle it decides which hardware thread owns the fetch stage and drives the `thread_id` consumed by the fetch unit, which forms the thread bit of the PC. Switches are event-driven on an i-cache miss, optionally time-sliced, and always pass through a one-cycle fetch bubble. Sits between hazard control, the i-cache, and the fetch unit.

## Interface
Parameters:
- QUANTUM, 16: RUN cycles per thread before a forced switch; legal range ≥2; only used with SCHED_QUANTUM_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_thread_en  in  2  bit t = thread t is allowed to run.
- i_miss  in  1  i-cache miss on the current thread's fetch this cycle.
- i_fill_done  in  2  bit t = thread t's outstanding miss has resolved (one-cycle pulse).
- i_hc_stall  in  1  hazard-control stall (i_hc.stall).
- o_thread_id  out  1  thread owning fetch (registered).
- o_switch  out  1  high during the SWITCH bubble cycle.
- o_fetch_stall  out  1  high in SWITCH and IDLE; OR'd into fetch stall.
- o_blocked  out  2  per-thread miss-blocked flags (registered).

## Operation
- runnable[t] = i_thread_en[t] & ~o_blocked[t]. Uses registered blocked, so a fill makes the thread runnable the cycle after i_fill_done.
- Blocked update: blocked[t] <= (blocked[t] & ~i_fill_done[t]) | (state==RUN & i_miss & t==o_thread_id). Set wins over clear when both occur on the same thread in the same cycle.
- States: IDLE, SWITCH, RUN. cur = o_thread_id, oth = ~cur.
- IDLE:
  - If runnable[oth], go to SWITCH and load o_thread_id=oth.
  - Else if runnable[cur], go to RUN directly with no bubble.
  - Else stay in IDLE.
- SWITCH: lasts exactly one cycle, then RUN. The quantum counter clears to 0.
- RUN triggers, evaluated in priority order:
  1. i_miss: always honoured, even during i_hc_stall. Go to SWITCH to oth if runnable[oth], else IDLE.
  2. ~i_thread_en[cur] and no stall: same destination as i_miss.
  3. Quantum expiry (counter==QUANTUM-1) and no stall: SWITCH to oth if runnable[oth], else stay in RUN with the counter cleared.
- Quantum counter: width $clog2(QUANTUM). Increments in RUN when ~i_hc_stall and no trigger fires. Holds while stalled. Clears on any state entry.
- While i_hc_stall is high, the enable-drop and quantum triggers are deferred, not lost. They re-evaluate each cycle.
- o_thread_id changes only on the edge that enters SWITCH, or on IDLE→RUN (never in this design, since IDLE→RUN keeps cur).

## Timing
- Reset values: state=IDLE, o_thread_id=0, o_blocked=2'b00, counter=0, o_switch=0, o_fetch_stall=1.
- All outputs are registered state or decode of registered state, with no combinational input-to-output path.
- Miss to new thread fetching: miss in cycle N, SWITCH in N+1 with o_thread_id updated, new thread fetches in N+2.
- Fill to rescheduling from IDLE: i_fill_done in N, IDLE sees runnable in N+1, RUN (same thread) in N+2.
- Reset mid-SWITCH or mid-RUN returns to reset values on the next edge. Blocked flags are cleared, so outstanding fills are ignored.
- i_miss in SWITCH or IDLE is ignored.

## Configuration
- SCHED_QUANTUM_EN defined: the quantum counter and trigger 3 are present, giving time-sliced round-robin.
- SCHED_QUANTUM_EN undefined: there is no counter and no QUANTUM dependence. Switching happens only on miss or enable drop, i.e. pure switch-on-event.

## Test plan
- Reset, then i_thread_en=2'b01 → o_fetch_stall=1 in cycle 1, RUN on thread 0 in cycle 2, o_switch never asserts.
- Both enabled, running thread 0, i_miss in cycle N → o_blocked=2'b01 and o_switch=1, o_thread_id=1 at N+1; RUN at N+2. Then i_fill_done=2'b01 → o_blocked=2'b00 next cycle.
- Both threads miss in turn (blocked=2'b11) → IDLE with o_fetch_stall=1. i_fill_done=2'b10 → SWITCH to thread 1, or direct RUN if cur=1.
- SCHED_QUANTUM_EN, QUANTUM=4, both runnable, no stall → o_switch pulses every 5 cycles, alternating o_thread_id. Holding i_hc_stall for 3 cycles at counter=3 delays the switch by exactly 3 cycles.
- Same-cycle i_miss and i_fill_done on the current thread → blocked set. Reset asserted during SWITCH → o_thread_id=0, o_blocked=0, IDLE next cycle.
